// File: rtl/vx_dispatch_splitter_if.sv
// Bundle between the issue-slice dispatch buffers, the splitter and the EX unit.
// slave : splitter view (consumes in_*, produces out_*).
// master: environment view (drives in_* and out_ready).
// Handshake: a transfer on a channel happens in a cycle where valid and ready
// are both high at the rising clock edge; a source holds valid and its payload
// stable until that transfer, and ready may depend combinationally on valid.
interface vx_dispatch_splitter_if #(
   parameter int NUM_INPUTS = 4,
   parameter int SIMD_WIDTH = 4,
   parameter int NUM_LANES  = 2,
   parameter int XLEN       = 32,
   parameter int HDR_W      = 64
);
   localparam int PID_W = ((SIMD_WIDTH / NUM_LANES) > 1) ? $clog2(SIMD_WIDTH / NUM_LANES) : 1;
   localparam int ISW   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

   logic [NUM_INPUTS-1:0]                   in_valid;
   logic [NUM_INPUTS-1:0]                   in_ready;
   logic [NUM_INPUTS*SIMD_WIDTH-1:0]        in_tmask;
   logic [NUM_INPUTS*3*SIMD_WIDTH*XLEN-1:0] in_rs_data;
   logic [NUM_INPUTS*HDR_W-1:0]             in_hdr;
   logic [NUM_INPUTS-1:0]                   in_sop;
   logic [NUM_INPUTS-1:0]                   in_eop;

   logic                                    out_valid;
   logic                                    out_ready;
   logic [NUM_LANES-1:0]                    out_tmask;
   logic [3*NUM_LANES*XLEN-1:0]             out_rs_data;
   logic [HDR_W-1:0]                        out_hdr;
   logic [ISW-1:0]                          out_isw;
   logic [PID_W-1:0]                        out_pid;
   logic                                    out_sop;
   logic                                    out_eop;

   modport master (
      output in_valid, in_tmask, in_rs_data, in_hdr, in_sop, in_eop, out_ready,
      input  in_ready, out_valid, out_tmask, out_rs_data, out_hdr, out_isw,
             out_pid, out_sop, out_eop
   );

   modport slave (
      input  in_valid, in_tmask, in_rs_data, in_hdr, in_sop, in_eop, out_ready,
      output in_ready, out_valid, out_tmask, out_rs_data, out_hdr, out_isw,
             out_pid, out_sop, out_eop
   );
endinterface

// File: rtl/vx_dispatch_splitter.sv
// Execute-side dispatch front end: round-robin arbiter over the issue slices,
// splitter of SIMD_WIDTH-wide instructions into NUM_LANES-wide packets, and a
// registered valid/ready output stage.
// Optional feature macro: DISPATCH_SPLIT_SKIP_EN (skip packets whose thread
// mask slice is all zero). Default build emits every packet.
module vx_dispatch_splitter #(
   parameter int NUM_INPUTS = 4,
   parameter int SIMD_WIDTH = 4,
   parameter int NUM_LANES  = 2,
   parameter int XLEN       = 32,
   parameter int HDR_W      = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   vx_dispatch_splitter_if.slave  bus,
   output logic                   dbg_state
);
   localparam int NUM_PKTS = SIMD_WIDTH / NUM_LANES;
   localparam int PID_W    = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
   localparam int ISW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int RS_IN_W  = 3 * SIMD_WIDTH * XLEN;
   localparam int RS_OUT_W = 3 * NUM_LANES * XLEN;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [ISW-1:0]       prio_q, prio_d;
   logic [ISW-1:0]       grant_q, grant_d;
   logic [PID_W-1:0]     pid_q, pid_d;

   logic                 out_valid_q, out_valid_d;
   logic [NUM_LANES-1:0] out_tmask_q, out_tmask_d;
   logic [RS_OUT_W-1:0]  out_rs_q, out_rs_d;
   logic [HDR_W-1:0]     out_hdr_q, out_hdr_d;
   logic [ISW-1:0]       out_isw_q, out_isw_d;
   logic [PID_W-1:0]     out_pid_q, out_pid_d;
   logic                 out_sop_q, out_sop_d;
   logic                 out_eop_q, out_eop_d;

   logic                  pick_valid;
   logic [ISW-1:0]        pick_idx;
   logic                  sel_valid;
   logic [ISW-1:0]        sel_idx;
   logic [SIMD_WIDTH-1:0] sel_tmask;
   logic [RS_IN_W-1:0]    sel_rs;
   logic [PID_W-1:0]      cur_pid;
   logic [PID_W-1:0]      next_pid;
   logic                  has_next;
   logic                  is_last;
   logic                  out_free;
   logic                  load_en;
   logic [NUM_INPUTS-1:0] in_ready_c;
   logic [NUM_LANES-1:0]  pkt_tmask;
   logic [RS_OUT_W-1:0]   pkt_rs;

   // Round-robin pick: first valid slice at or after the priority pointer.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (!pick_valid && bus.in_valid[(int'(prio_q) + i) % NUM_INPUTS]) begin
            pick_valid = 1'b1;
            pick_idx   = ISW'((int'(prio_q) + i) % NUM_INPUTS);
         end
      end
   end

   // Source selection: the locked grant while busy, the fresh pick while idle.
   always_comb begin
      sel_idx   = (state_q == S_BUSY) ? grant_q : pick_idx;
      sel_valid = (state_q == S_BUSY) ? bus.in_valid[grant_q] : pick_valid;
      sel_tmask = bus.in_tmask[int'(sel_idx) * SIMD_WIDTH +: SIMD_WIDTH];
      sel_rs    = bus.in_rs_data[int'(sel_idx) * RS_IN_W +: RS_IN_W];
   end

`ifdef DISPATCH_SPLIT_SKIP_EN
   logic [NUM_PKTS-1:0] pkt_nz;
   logic [PID_W-1:0]    first_pid;

   // Packet walk that skips empty lane groups; an all-zero mask still emits packet 0.
   always_comb begin
      for (int p = 0; p < NUM_PKTS; p++) begin
         pkt_nz[p] = |sel_tmask[p * NUM_LANES +: NUM_LANES];
      end
      first_pid = '0;
      for (int p = NUM_PKTS - 1; p >= 0; p--) begin
         if (pkt_nz[p]) first_pid = PID_W'(p);
      end
      cur_pid  = (state_q == S_BUSY) ? pid_q : first_pid;
      has_next = 1'b0;
      next_pid = cur_pid;
      for (int p = NUM_PKTS - 1; p >= 0; p--) begin
         if ((p > int'(cur_pid)) && pkt_nz[p]) begin
            has_next = 1'b1;
            next_pid = PID_W'(p);
         end
      end
   end
`else
   // Packet walk over every lane group in order.
   always_comb begin
      cur_pid  = (state_q == S_BUSY) ? pid_q : '0;
      has_next = (int'(cur_pid) < NUM_PKTS - 1);
      next_pid = cur_pid + PID_W'(1);
   end
`endif

   // Extract the current packet's lane group from the selected instruction.
   always_comb begin
      pkt_tmask = sel_tmask[int'(cur_pid) * NUM_LANES +: NUM_LANES];
      pkt_rs    = '0;
      for (int r = 0; r < 3; r++) begin
         pkt_rs[r * NUM_LANES * XLEN +: NUM_LANES * XLEN] =
            sel_rs[r * SIMD_WIDTH * XLEN + int'(cur_pid) * NUM_LANES * XLEN +: NUM_LANES * XLEN];
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: stay busy until the final packet of the instruction loads.
   always_comb begin
      state_d = state_q;
      if (load_en) state_d = is_last ? S_IDLE : S_BUSY;
   end

   // FSM outputs: load enable, upstream accept, lock/pid/priority and output stage updates.
   always_comb begin
      is_last     = !has_next;
      out_free    = !out_valid_q || bus.out_ready;
      load_en     = out_free && sel_valid && !reset;
      in_ready_c  = '0;
      if (load_en && is_last) in_ready_c[sel_idx] = 1'b1;

      prio_d      = prio_q;
      grant_d     = grant_q;
      pid_d       = pid_q;
      out_valid_d = out_valid_q;
      out_tmask_d = out_tmask_q;
      out_rs_d    = out_rs_q;
      out_hdr_d   = out_hdr_q;
      out_isw_d   = out_isw_q;
      out_pid_d   = out_pid_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;

      if (out_free) out_valid_d = load_en;

      if (load_en) begin
         out_tmask_d = pkt_tmask;
         out_rs_d    = pkt_rs;
         out_hdr_d   = bus.in_hdr[int'(sel_idx) * HDR_W +: HDR_W];
         out_isw_d   = sel_idx;
         out_pid_d   = cur_pid;
         out_sop_d   = bus.in_sop[sel_idx] && (state_q == S_IDLE);
         out_eop_d   = bus.in_eop[sel_idx] && is_last;
         if (is_last) begin
            pid_d  = '0;
            prio_d = (sel_idx == ISW'(NUM_INPUTS - 1)) ? '0 : sel_idx + ISW'(1);
         end else begin
            pid_d   = next_pid;
            grant_d = sel_idx;
         end
      end
   end

   // Datapath and arbiter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q      <= '0;
         grant_q     <= '0;
         pid_q       <= '0;
         out_valid_q <= 1'b0;
         out_tmask_q <= '0;
         out_rs_q    <= '0;
         out_hdr_q   <= '0;
         out_isw_q   <= '0;
         out_pid_q   <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
      end else begin
         prio_q      <= prio_d;
         grant_q     <= grant_d;
         pid_q       <= pid_d;
         out_valid_q <= out_valid_d;
         out_tmask_q <= out_tmask_d;
         out_rs_q    <= out_rs_d;
         out_hdr_q   <= out_hdr_d;
         out_isw_q   <= out_isw_d;
         out_pid_q   <= out_pid_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_tmask   = out_tmask_q;
   assign bus.out_rs_data = out_rs_q;
   assign bus.out_hdr     = out_hdr_q;
   assign bus.out_isw     = out_isw_q;
   assign bus.out_pid     = out_pid_q;
   assign bus.out_sop     = out_sop_q;
   assign bus.out_eop     = out_eop_q;
   assign dbg_state       = (state_q == S_BUSY);

endmodule

// File: doc/vx_dispatch_splitter.md
# vx_dispatch_splitter

Execute-side front end for one EX unit type. Sits directly downstream of the per-issue-slice dispatch buffers. It round-robin arbitrates among `NUM_INPUTS` issue slices, splits each accepted `SIMD_WIDTH`-wide instruction into `SIMD_WIDTH/NUM_LANES` lane packets, and presents them to the execute unit through a registered valid/ready output. Packet framing uses `sop`/`eop`, so downstream units can reassemble multi-packet instructions.

## Interface
Parameters:
- `NUM_INPUTS`, 4: issue slices feeding this unit.
- `SIMD_WIDTH`, 4: threads per incoming instruction.
- `NUM_LANES`, 2: execute lanes. Power of two; divides `SIMD_WIDTH`.
- `XLEN`, 32: operand width.
- `HDR_W`, 64: opaque header width (uuid, wis, PC, wb, rd, op_type, op_args, packed by caller).
- Derived: `NUM_PKTS = SIMD_WIDTH/NUM_LANES`; `PID_W = max(1, clog2(NUM_PKTS))`; `ISW = max(1, clog2(NUM_INPUTS))`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, `NUM_INPUTS`: per-slice request.
- `in_ready`, out, `NUM_INPUTS`: per-slice accept. Pulses only on the last packet of that slice's instruction.
- `in_tmask`, in, `NUM_INPUTS×SIMD_WIDTH`: thread mask.
- `in_rs_data`, in, `NUM_INPUTS×3×SIMD_WIDTH×XLEN`: rs1/rs2/rs3 data.
- `in_hdr`, in, `NUM_INPUTS×HDR_W`: header.
- `in_sop`, `in_eop`, in, `NUM_INPUTS` each: upstream framing.
- `out_valid`, out, 1; `out_ready`, in, 1: output handshake.
- `out_tmask`, out, `NUM_LANES`.
- `out_rs_data`, out, `3×NUM_LANES×XLEN`.
- `out_hdr`, out, `HDR_W`.
- `out_isw`, out, `ISW`: source slice index.
- `out_pid`, out, `PID_W`: packet index (lane base = `pid×NUM_LANES`).
- `out_sop`, `out_eop`, out, 1 each.

## Operation
- **Arbiter.** Round-robin across `in_valid`.
  - Priority starts at slice 0 after reset.
  - After an instruction is consumed from slice k, the highest priority moves to k+1 mod `NUM_INPUTS`.
  - The grant is locked from the first emitted packet until the last packet is loaded. Input data must stay stable while valid.
- **Splitter.** Packet p carries threads `[p×NUM_LANES +: NUM_LANES]` of tmask and each rs array.
  - A `pid` counter walks the packets that are to be emitted.
  - On the load of the final packet: assert `in_ready[grant]`, release the lock, reset `pid` to 0.
- **Framing.**
  - `out_sop = in_sop & first emitted packet`.
  - `out_eop = in_eop & last emitted packet`.
  - `out_hdr` and `out_isw` are constant across the packets of one instruction.
- **States.**
  - IDLE: no lock. On any `in_valid`, take the grant and load a packet. If that packet is the only one, stay IDLE; otherwise go to BUSY.
  - BUSY: on each load, advance to the next packet. Return to IDLE after the last packet loads.
- **Output register.** Loads when `!out_valid | out_ready`.
- **`NUM_LANES == SIMD_WIDTH`.** One packet per instruction, `pid` fixed at 0. Pure registered arbiter.

## Timing
- Reset values:
  - `out_valid` = 0, `in_ready` = 0.
  - `out_pid`, `out_isw`, `out_sop`, `out_eop`, `out_tmask` = 0.
  - Priority = 0, state = IDLE.
- Latency: a packet loaded at edge N is visible from cycle N+1. An instruction with P emitted packets and `out_ready` held high takes P cycles.
- Throughput: 1 packet/cycle with `out_ready` held high.
- Backpressure: with `out_ready` low and `out_valid` high, nothing loads. The lock, `pid`, and all `in_ready` bits hold.
- `in_ready` is combinational. It is high only in the cycle the final packet loads, and only for the granted slice.
- Simultaneous events:
  - A new instruction from a different slice can load in the cycle after the previous final packet. There are no bubbles.
  - A valid that appears on a non-granted slice mid-instruction is ignored until the lock releases.
- Reset mid-instruction: the partial instruction is dropped and no `in_ready` is issued. Upstream re-presents it.

## Configuration
- `DISPATCH_SPLIT_SKIP_EN` defined:
  - Packets whose tmask slice is all zero are skipped. The `pid` counter jumps to the next nonzero packet (leading-zero search over packet-OR bits).
  - An all-zero `in_tmask` emits exactly packet 0 with tmask 0, carrying both sop and eop from the input.
- Undefined: all `NUM_PKTS` packets are emitted regardless of tmask.

## Test plan
- Single slice 0, tmask 4'b1111, sop=eop=1, `out_ready` held 1 → two packets on consecutive cycles:
  - pid 0: sop=1, eop=0, tmask 2'b11.
  - pid 1: sop=0, eop=1.
  - `in_ready[0]` high only in the second load cycle.
- Slices 0–3 all valid continuously → `out_isw` sequence 0,0,1,1,2,2,3,3,0,… with no idle cycles.
- Backpressure: `out_ready` held 0 for 5 cycles mid-instruction → output data, pid, and lock hold. Resumes at pid 1 when `out_ready` rises.
- `DISPATCH_SPLIT_SKIP_EN`, tmask 4'b1100 → exactly one packet: pid 1, sop=1, eop=1, tmask 2'b11.
- `DISPATCH_SPLIT_SKIP_EN`, tmask 4'b0000 → one packet: pid 0, tmask 0, sop=eop=1. Without the macro: two packets.
- Reset asserted after pid 0 has loaded → `out_valid` 0 the next cycle, `in_ready` never asserted. The re-presented instruction restarts at pid 0 with priority 0.
